// File: rtl/prbs8_pkg.sv
// prbs8_pkg: PRBS8 sequence constants and FSM encoding shared by LFSR8 and the checker
package prbs8_pkg;
  localparam logic [7:0] PRBS_TAP_MASK = 8'b1011_1000;
  localparam int PRBS_PERIOD = 255;
  typedef enum logic {ST_SEARCH = 1'b0, ST_LOCKED = 1'b1} state_e;
  function automatic logic prbs8_pred(input logic [7:0] h);
    return ^(h & PRBS_TAP_MASK);
  endfunction
endpackage

// File: rtl/prbs8_checker_sat_counter16.sv
// sat_counter16: 16-bit saturating counter with clear-over-increment priority
module sat_counter16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] cnt
);
  logic [15:0] cnt_q, cnt_d;
  // clear wins; increment sticks at all-ones
  always_comb cnt_d = clr ? 16'd0 : (inc && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
  // count register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= 16'd0;
    else cnt_q <= cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/prbs8_checker.sv
// prbs8_checker: synchronises a local PRBS8 reference to a serial stream, then counts bit errors and tracks lock
module prbs8_checker
  import prbs8_pkg::*;
#(
  parameter int LOCK_THRESH = 16,
  parameter int WINDOW      = 64,
  parameter int LOSS_THRESH = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        DIN,
  input  logic        DIN_EN,
  input  logic        CLR_CNT,
  output logic        LOCK,
  output logic        ERR,
  output logic [15:0] ERR_COUNT
);
  localparam logic [7:0] LOCK_T = 8'(LOCK_THRESH);
  localparam logic [7:0] WIN_T  = 8'(WINDOW);
  localparam logic [7:0] LOSS_T = 8'(LOSS_THRESH);
  state_e      state_q, state_d;
  logic [7:0]  hist_q, hist_d;
  logic [3:0]  fill_q, fill_d;
  logic [7:0]  run_q, run_d;
  logic [7:0]  wbits_q, wbits_d;
  logic [7:0]  werr_q, werr_d;
  logic        err_q, err_d;
  logic        cnt_inc;
  logic        pred, miss;
  logic [7:0]  wbits_n, werr_n;
  assign pred    = prbs8_pred(hist_q);
  assign miss    = DIN != pred;
  assign wbits_n = wbits_q + 8'd1;
  assign werr_n  = werr_q + {7'd0, miss};
  // SEARCH trains history from DIN; LOCKED free-runs the reference and scores DIN against it
  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    run_d   = run_q;
    wbits_d = wbits_q;
    werr_d  = werr_q;
    err_d   = 1'b0;
    cnt_inc = 1'b0;
    if (DIN_EN) begin
      if (state_q == ST_SEARCH) begin
        hist_d = {hist_q[6:0], DIN};
        fill_d = (fill_q == 4'd8) ? fill_q : fill_q + 4'd1;
        if (fill_q == 4'd8) begin
          run_d = (!miss && hist_q != 8'd0) ? run_q + 8'd1 : 8'd0;
          if (run_d == LOCK_T) begin
            state_d = ST_LOCKED;
            wbits_d = 8'd0;
            werr_d  = 8'd0;
          end
        end
      end else begin
        hist_d  = {hist_q[6:0], pred};
        err_d   = miss;
        cnt_inc = miss;
        if (werr_n == LOSS_T) begin
          state_d = ST_SEARCH;
          fill_d  = 4'd0;
          run_d   = 8'd0;
          wbits_d = 8'd0;
          werr_d  = 8'd0;
        end else if (wbits_n == WIN_T) begin
          wbits_d = 8'd0;
          werr_d  = 8'd0;
        end else begin
          wbits_d = wbits_n;
          werr_d  = werr_n;
        end
      end
    end
  end
  // state registers
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      state_q <= ST_SEARCH;
      hist_q  <= 8'd0;
      fill_q  <= 4'd0;
      run_q   <= 8'd0;
      wbits_q <= 8'd0;
      werr_q  <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      run_q   <= run_d;
      wbits_q <= wbits_d;
      werr_q  <= werr_d;
      err_q   <= err_d;
    end
  sat_counter16 u_cnt (
    .clk  (CLK),
    .rst_n(RESET),
    .clr  (CLR_CNT),
    .inc  (cnt_inc),
    .cnt  (ERR_COUNT)
  );
  assign LOCK = state_q == ST_LOCKED;
  assign ERR  = err_q;
endmodule

// File: tb/tb_prbs8_checker.sv
// tb_prbs8_checker: directed scenario checks of lock, error counting, loss/relock, gaps, saturation and async reset
module tb_prbs8_checker;
  localparam int N_CLEAN = prbs8_pkg::PRBS_PERIOD + 45;
  logic clk, rst_n, din, din_en, clr_cnt, lock, err;
  logic [15:0] err_count;
  logic din2, en2, clr2, lock2, err2;
  logic [15:0] cnt2;
  logic [7:0] g;
  int tests, fails;

  prbs8_checker dut (
    .CLK(clk), .RESET(rst_n), .DIN(din), .DIN_EN(din_en), .CLR_CNT(clr_cnt),
    .LOCK(lock), .ERR(err), .ERR_COUNT(err_count)
  );
  prbs8_checker #(.LOCK_THRESH(16), .WINDOW(255), .LOSS_THRESH(255)) dut_sat (
    .CLK(clk), .RESET(rst_n), .DIN(din2), .DIN_EN(en2), .CLR_CNT(clr2),
    .LOCK(lock2), .ERR(err2), .ERR_COUNT(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic gen_bit();
    logic b;
    b = g[7] ^ g[5] ^ g[4] ^ g[3];
    g = {g[6:0], b};
    return b;
  endfunction

  task automatic send(input logic b);
    @(negedge clk);
    din = b;
    din_en = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    din_en = 1'b0;
    din = 1'($urandom);
    @(posedge clk);
    #1;
  endtask

  task automatic send2(input logic b);
    @(negedge clk);
    din2 = b;
    en2 = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    din_en = 1'b0;
    en2 = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    g = 8'h01;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    tests++; if (lock !== 1'b0) begin fails++; $display("FAIL reset_lock got %b want 0", lock); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", err); end
    tests++; if (err_count !== 16'd0) begin fails++; $display("FAIL reset_cnt got %0d want 0", err_count); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    tests++; if (lock !== 1'b0) begin fails++; $display("FAIL post_reset_lock got %b want 0", lock); end
  endtask

  task automatic test_clean_lock();
    do_reset();
    for (int k = 1; k <= N_CLEAN; k++) begin
      send(gen_bit());
      tests++; if (lock !== (k >= 24)) begin fails++; $display("FAIL clean_lock bit %0d got %b want %b", k, lock, k >= 24); end
      tests++; if (err !== 1'b0) begin fails++; $display("FAIL clean_err bit %0d got %b want 0", k, err); end
    end
    tests++; if (err_count !== 16'd0) begin fails++; $display("FAIL clean_cnt got %0d want 0", err_count); end
  endtask

  task automatic test_single_error();
    logic b;
    do_reset();
    for (int k = 1; k <= 150; k++) begin
      b = gen_bit();
      send(k == 100 ? ~b : b);
      if (k >= 99) begin
        tests++; if (err !== (k == 100)) begin fails++; $display("FAIL single_err bit %0d got %b want %b", k, err, k == 100); end
        tests++; if (lock !== 1'b1) begin fails++; $display("FAIL single_lock bit %0d got %b want 1", k, lock); end
      end
      if (k == 100) begin
        tests++; if (err_count !== 16'd1) begin fails++; $display("FAIL single_cnt_at got %0d want 1", err_count); end
      end
    end
    tests++; if (err_count !== 16'd1) begin fails++; $display("FAIL single_cnt_end got %0d want 1", err_count); end
  endtask

  task automatic test_all_zero();
    do_reset();
    for (int k = 1; k <= 200; k++) begin
      send(1'b0);
      tests++; if (lock !== 1'b0) begin fails++; $display("FAIL zero_lock bit %0d got %b want 0", k, lock); end
    end
    tests++; if (err_count !== 16'd0) begin fails++; $display("FAIL zero_cnt got %0d want 0", err_count); end
  endtask

  task automatic test_loss_relock();
    do_reset();
    for (int k = 1; k <= 40; k++) send(gen_bit());
    tests++; if (lock !== 1'b1) begin fails++; $display("FAIL loss_prelock got %b want 1", lock); end
    for (int e = 1; e <= 8; e++) begin
      send(gen_bit());
      tests++; if (err !== 1'b0) begin fails++; $display("FAIL loss_gap_err %0d got %b want 0", e, err); end
      send(~gen_bit());
      tests++; if (err !== 1'b1) begin fails++; $display("FAIL loss_err %0d got %b want 1", e, err); end
      tests++; if (lock !== (e < 8)) begin fails++; $display("FAIL loss_lock %0d got %b want %b", e, lock, e < 8); end
    end
    tests++; if (err_count !== 16'd8) begin fails++; $display("FAIL loss_cnt got %0d want 8", err_count); end
    for (int k = 1; k <= 24; k++) begin
      send(gen_bit());
      tests++; if (lock !== (k >= 24)) begin fails++; $display("FAIL relock bit %0d got %b want %b", k, lock, k >= 24); end
      tests++; if (err !== 1'b0) begin fails++; $display("FAIL relock_err bit %0d got %b want 0", k, err); end
    end
    tests++; if (err_count !== 16'd8) begin fails++; $display("FAIL relock_cnt got %0d want 8", err_count); end
    clr_cnt = 1'b1;
    send(~gen_bit());
    clr_cnt = 1'b0;
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL clr_err got %b want 1", err); end
    tests++; if (err_count !== 16'd0) begin fails++; $display("FAIL clr_cnt got %0d want 0", err_count); end
    send(~gen_bit());
    tests++; if (err_count !== 16'd1) begin fails++; $display("FAIL clr_next_cnt got %0d want 1", err_count); end
  endtask

  task automatic test_gappy();
    logic b;
    logic was_lock;
    do_reset();
    for (int k = 1; k <= N_CLEAN; k++) begin
      repeat ($urandom_range(0, 3)) begin
        was_lock = lock;
        idle();
        tests++; if (err !== 1'b0 || lock !== was_lock) begin fails++; $display("FAIL gap_idle bit %0d got err=%b lock=%b want err=0 lock=%b", k, err, lock, was_lock); end
      end
      b = gen_bit();
      send(k == 100 ? ~b : b);
      tests++; if (lock !== (k >= 24)) begin fails++; $display("FAIL gap_lock bit %0d got %b want %b", k, lock, k >= 24); end
      tests++; if (err !== (k == 100)) begin fails++; $display("FAIL gap_err bit %0d got %b want %b", k, err, k == 100); end
    end
    tests++; if (err_count !== 16'd1) begin fails++; $display("FAIL gap_cnt got %0d want 1", err_count); end
  endtask

  task automatic test_saturation();
    int errs;
    logic e;
    do_reset();
    for (int k = 1; k <= 24; k++) send2(gen_bit());
    tests++; if (lock2 !== 1'b1) begin fails++; $display("FAIL sat_lock got %b want 1", lock2); end
    errs = 0;
    for (int i = 0; errs < 66000; i++) begin
      e = (i % 255) != 254;
      send2(e ? ~gen_bit() : gen_bit());
      if (e) errs++;
      if (e && errs == 65534) begin
        tests++; if (cnt2 !== 16'd65534) begin fails++; $display("FAIL sat_pre got %0d want 65534", cnt2); end
      end
    end
    en2 = 1'b0;
    tests++; if (cnt2 !== 16'hFFFF) begin fails++; $display("FAIL sat_cnt got %h want ffff", cnt2); end
    tests++; if (lock2 !== 1'b1) begin fails++; $display("FAIL sat_lock_end got %b want 1", lock2); end
    tests++; if (err2 !== 1'b1) begin fails++; $display("FAIL sat_err got %b want 1", err2); end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int k = 1; k <= 30; k++) send(gen_bit());
    send(~gen_bit());
    tests++; if (lock !== 1'b1 || err !== 1'b1 || err_count !== 16'd1) begin fails++; $display("FAIL arst_pre got lock=%b err=%b cnt=%0d want 1 1 1", lock, err, err_count); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (lock !== 1'b0) begin fails++; $display("FAIL arst_lock got %b want 0", lock); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL arst_err got %b want 0", err); end
    tests++; if (err_count !== 16'd0) begin fails++; $display("FAIL arst_cnt got %0d want 0", err_count); end
    @(negedge clk);
    din_en = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    din = 1'b0;
    din_en = 1'b0;
    clr_cnt = 1'b0;
    din2 = 1'b0;
    en2 = 1'b0;
    clr2 = 1'b0;
    g = 8'h01;
    test_reset();
    test_clean_lock();
    test_single_error();
    test_all_zero();
    test_loss_relock();
    test_gappy();
    test_saturation();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
